// File: rtl/btn_cmd_scheduler.sv
// Turns rising edges of debounced buttons into one-shot commands, arbitrated
// round-robin and issued over valid/ready with a programmable hold-off gap.
module btn_cmd_scheduler #(
    parameter int          N_BTN   = 4,
    parameter logic [23:0] HOLDOFF = 24'd1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_db,
    output logic             cmd_valid,
    output logic [2:0]       cmd_id,
    input  logic             cmd_ready,
    output logic [N_BTN-1:0] pending,
    output logic             busy,
    output logic [7:0]       dropped_cnt
);

    typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

    state_t           state_q, state_d;
    logic [N_BTN-1:0] prev_q, pending_q, pending_d;
    logic [N_BTN-1:0] rise, acc_mask;
    logic [2:0]       ptr_q, ptr_d, id_q, id_d;
    logic             valid_q, valid_d, busy_q, busy_d;
    logic [7:0]       drop_q, drop_d;
    logic [23:0]      cnt_q, cnt_d;
    logic             accept, drop_hit;
    logic             found_hi, found_lo;
    logic [2:0]       win_hi, win_lo, winner;

    assign accept = valid_q & cmd_ready;
    assign rise   = btn_db & ~prev_q;

    always_comb begin
        acc_mask = '0;
        for (int i = 0; i < N_BTN; i++)
            acc_mask[i] = accept && (id_q == 3'(i));
    end

    // A rise on the channel being accepted is a fresh event, not an overrun.
    assign pending_d = (pending_q & ~acc_mask) | rise;
    assign drop_hit  = |(rise & pending_q & ~acc_mask);
    assign drop_d    = (drop_hit && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    // Round-robin: lowest pending index at or above ptr, else lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                if (3'(i) >= ptr_q) begin
                    found_hi = 1'b1;
                    win_hi   = 3'(i);
                end else begin
                    found_lo = 1'b1;
                    win_lo   = 3'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found_hi || found_lo) begin
                    id_d    = winner;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    valid_d = 1'b0;
                    ptr_d   = (id_q == 3'(N_BTN - 1)) ? 3'd0 : id_q + 3'd1;
                    if (HOLDOFF == 24'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLDOFF;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q - 24'd1;
                if (cnt_q == 24'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (|pending_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= btn_db;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_id      = id_q;
    assign pending     = pending_q;
    assign busy        = busy_q;
    assign dropped_cnt = drop_q;

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Directed bench: instance a uses HOLDOFF=4, instance b uses HOLDOFF=0.
module tb_btn_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_btn, b_btn, a_pend, b_pend;
    logic       a_rdy, b_rdy, a_vld, b_vld, a_busy, b_busy;
    logic [2:0] a_id, b_id;
    logic [7:0] a_drop, b_drop;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    btn_cmd_scheduler #(.N_BTN(4), .HOLDOFF(24'd4)) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_db(a_btn), .cmd_valid(a_vld), .cmd_id(a_id),
        .cmd_ready(a_rdy), .pending(a_pend), .busy(a_busy), .dropped_cnt(a_drop));

    btn_cmd_scheduler #(.N_BTN(4), .HOLDOFF(24'd0)) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_db(b_btn), .cmd_valid(b_vld), .cmd_id(b_id),
        .cmd_ready(b_rdy), .pending(b_pend), .busy(b_busy), .dropped_cnt(b_drop));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] pe;
        int         nvld;
        logic [2:0] seen_id;

        rst_n = 1'b0;
        a_btn = '0; b_btn = '0; a_rdy = 1'b0; b_rdy = 1'b0;
        #2;
        chk("rst_vld", 32'(a_vld), 0);
        chk("rst_id", 32'(a_id), 0);
        chk("rst_pend", 32'(a_pend), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_drop", 32'(a_drop), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single press on channel 2, HOLDOFF=4
        a_rdy = 1'b1;
        a_btn = 4'b0100;
        tick();
        chk("sp_pend", 32'(a_pend), 32'h4);
        chk("sp_vld0", 32'(a_vld), 0);
        chk("sp_busy0", 32'(a_busy), 1);
        tick();
        chk("sp_vld1", 32'(a_vld), 1);
        chk("sp_id", 32'(a_id), 2);
        tick();
        chk("sp_acc_vld", 32'(a_vld), 0);
        chk("sp_acc_pend", 32'(a_pend), 0);
        chk("sp_hold_busy", 32'(a_busy), 1);
        tick(); tick(); tick();
        chk("sp_hold_busy2", 32'(a_busy), 1);
        tick();
        chk("sp_idle_busy", 32'(a_busy), 0);
        chk("sp_idle_vld", 32'(a_vld), 0);
        a_btn = '0; a_rdy = 1'b0;
        tick();

        // round-robin on instance b, HOLDOFF=0
        b_btn = 4'b1111;
        tick();
        chk("rr_pend", 32'(b_pend), 32'hF);
        tick();
        for (int s = 0; s < 3; s++) begin
            chk("rr_stall_vld", 32'(b_vld), 1);
            chk("rr_stall_id", 32'(b_id), 0);
            tick();
        end
        pe = 4'hF;
        b_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_vld", 32'(b_vld), 1);
            chk("rr_id", 32'(b_id), 32'(k));
            tick();
            pe[k] = 1'b0;
            chk("rr_bubble", 32'(b_vld), 0);
            chk("rr_pend_k", 32'(b_pend), 32'(pe));
            if (k < 3) tick();
        end
        chk("rr_busy", 32'(b_busy), 0);
        chk("rr_drop", 32'(b_drop), 0);
        b_btn = '0; b_rdy = 1'b0;
        tick();

        // stall and drop on channel 1
        b_btn = 4'b0010;
        tick();
        tick();
        chk("sd_vld", 32'(b_vld), 1);
        chk("sd_id", 32'(b_id), 1);
        for (int p = 0; p < 3; p++) begin
            b_btn = 4'b0000; tick();
            b_btn = 4'b0010; tick();
        end
        chk("sd_drop3", 32'(b_drop), 3);
        chk("sd_pend", 32'(b_pend), 32'h2);
        chk("sd_id_stable", 32'(b_id), 1);
        for (int p = 0; p < 300; p++) begin
            b_btn = 4'b0000; tick();
            b_btn = 4'b0010; tick();
        end
        chk("sd_sat", 32'(b_drop), 255);
        chk("sd_pend2", 32'(b_pend), 32'h2);
        b_rdy = 1'b1;
        tick();
        chk("sd_acc_vld", 32'(b_vld), 0);
        chk("sd_acc_pend", 32'(b_pend), 0);
        b_btn = '0; b_rdy = 1'b0;

        // accept and rise on the same edge, instance a
        a_btn = 4'b0001;
        tick();
        chk("ar_pend", 32'(a_pend), 32'h1);
        tick();
        chk("ar_vld", 32'(a_vld), 1);
        chk("ar_id", 32'(a_id), 0);
        a_btn = 4'b0000;
        tick();
        a_btn = 4'b0001;
        a_rdy = 1'b1;
        tick();
        chk("ar_acc_vld", 32'(a_vld), 0);
        chk("ar_pend_kept", 32'(a_pend), 32'h1);
        chk("ar_drop", 32'(a_drop), 0);
        tick(); tick(); tick(); tick();
        chk("ar_hold_vld", 32'(a_vld), 0);
        tick();
        chk("ar_vld2", 32'(a_vld), 1);
        chk("ar_id2", 32'(a_id), 0);
        tick();
        chk("ar_acc2_pend", 32'(a_pend), 0);
        a_rdy = 1'b0; a_btn = '0;
        for (int s = 0; s < 5; s++) tick();

        // async reset while offering
        a_btn = 4'b0011;
        tick();
        chk("rs_pend", 32'(a_pend), 32'h3);
        tick();
        chk("rs_vld", 32'(a_vld), 1);
        chk("rs_id", 32'(a_id), 1);
        #3;
        rst_n = 1'b0;
        a_btn = 4'b0001;
        #1;
        chk("rs_async_vld", 32'(a_vld), 0);
        chk("rs_async_pend", 32'(a_pend), 0);
        chk("rs_async_drop", 32'(b_drop), 0);
        chk("rs_async_busy", 32'(a_busy), 0);
        tick(); tick();
        rst_n = 1'b1;
        a_rdy = 1'b1;
        nvld = 0;
        seen_id = 3'd7;
        for (int s = 0; s < 20; s++) begin
            tick();
            if (a_vld) begin
                nvld++;
                seen_id = a_id;
            end
        end
        chk("rs_cmd_count", 32'(nvld), 1);
        chk("rs_cmd_id", 32'(seen_id), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
